// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous input
// latching, PWM brightness, per-digit blank/blink, decimal points and optional hex.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 1024,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_EN       = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_code,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES);

  logic [PRESC_W-1:0]      presc_reg, presc_next;
  logic [BRIGHT_W-1:0]     phase_reg, phase_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [BLINK_W-1:0]      blink_cnt_reg, blink_cnt_next;
  logic                    blink_phase_reg, blink_phase_next;
  logic [4*NUM_DIGITS-1:0] code_reg, code_next;
  logic [NUM_DIGITS-1:0]   dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
  logic [NUM_DIGITS-1:0]   blink_reg, blink_next;
  logic [BRIGHT_W-1:0]     bright_reg, bright_next;
  logic [NUM_DIGITS-1:0]   anode_reg, anode_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_out_reg, dp_out_next;

  logic       tick, slot_end, frame_boundary, lit;
  logic [3:0] cur_code;
  logic [6:0] cur_decode;
  logic [3:0]            digit_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_on;

  always_comb begin
    tick           = (presc_reg == PRESC_LAST);
    slot_end       = tick && (phase_reg == '1);
    frame_boundary = (presc_reg == '0) && (phase_reg == '0) && (idx_reg == '0);

    presc_next = tick ? '0 : presc_reg + 1'b1;
    phase_next = tick ? phase_reg + 1'b1 : phase_reg;
    idx_next   = idx_reg;
    if (slot_end)
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

    code_next   = frame_boundary ? digits_code : code_reg;
    dp_next     = frame_boundary ? dp_in       : dp_reg;
    blank_next  = frame_boundary ? blank_in    : blank_reg;
    blink_next  = frame_boundary ? blink_in    : blink_reg;
    bright_next = frame_boundary ? brightness  : bright_reg;

    // Boundaries are counted from reset; the counter restarts at 1 because the
    // toggling boundary itself is the first frame of the new half-period.
    blink_cnt_next   = blink_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (frame_boundary) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next   = BLINK_W'(1);
        blink_phase_next = ~blink_phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
  end

  // Display decisions use the values being latched this cycle, so the first
  // slot of a frame already reflects the newly captured inputs.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_code[gi] = code_next[4*gi +: 4];
    assign digit_on[gi]   = ~blank_next[gi] & ~(blink_next[gi] & blink_phase_next);
  end

  always_comb begin
    cur_code = digit_code[idx_reg];
    lit = (phase_reg < bright_next) && digit_on[idx_reg] &&
          ((HEX_EN != 0) || (cur_code < 4'd10));
  end

  always_comb begin
    cur_decode = 7'h7F;
    case (cur_code)
      4'h0: cur_decode = 7'b0000001;
      4'h1: cur_decode = 7'b1001111;
      4'h2: cur_decode = 7'b0010010;
      4'h3: cur_decode = 7'b0000110;
      4'h4: cur_decode = 7'b1001100;
      4'h5: cur_decode = 7'b0100100;
      4'h6: cur_decode = 7'b0100000;
      4'h7: cur_decode = 7'b0001111;
      4'h8: cur_decode = 7'b0000000;
      4'h9: cur_decode = 7'b0000100;
      4'hA: cur_decode = 7'b0001000;
      4'hB: cur_decode = 7'b1100000;
      4'hC: cur_decode = 7'b0110001;
      4'hD: cur_decode = 7'b1000010;
      4'hE: cur_decode = 7'b0110000;
      4'hF: cur_decode = 7'b0111000;
      default: cur_decode = 7'h7F;
    endcase
  end

  always_comb begin
    anode_next  = '1;
    seg_next    = 7'h7F;
    dp_out_next = 1'b1;
    if (lit) begin
      anode_next  = ~(NUM_DIGITS'(1) << idx_reg);
      seg_next    = cur_decode;
      dp_out_next = ~dp_next[idx_reg];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_reg       <= '0;
      phase_reg       <= '0;
      idx_reg         <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      code_reg        <= '0;
      dp_reg          <= '0;
      blank_reg       <= '1;
      blink_reg       <= '0;
      bright_reg      <= '0;
      anode_reg       <= '1;
      seg_reg         <= 7'h7F;
      dp_out_reg      <= 1'b1;
    end else begin
      presc_reg       <= presc_next;
      phase_reg       <= phase_next;
      idx_reg         <= idx_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
      code_reg        <= code_next;
      dp_reg          <= dp_next;
      blank_reg       <= blank_next;
      blink_reg       <= blink_next;
      bright_reg      <= bright_next;
      anode_reg       <= anode_next;
      seg_reg         <= seg_next;
      dp_out_reg      <= dp_out_next;
    end
  end

  // Counters sit at zero while reset is held, so the pulse is masked until release.
  assign frame_start = frame_boundary & ~reset;
  assign anode       = anode_reg;
  assign segments    = seg_reg;
  assign dp_out      = dp_out_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver: a frame/slot arithmetic model predicts
// every output cycle for a hex-enabled and a hex-disabled instance.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int TD    = 2;
  localparam int BW    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = TD * (1 << BW);
  localparam int FRAME = N * SLOT;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [4*N-1:0] digits_code = '0;
  logic [N-1:0]  dp_in = '0, blank_in = '0, blink_in = '0;
  logic [BW-1:0] brightness = '0;
  logic [N-1:0]  anode, anode_h0;
  logic [6:0]    segments, segments_h0;
  logic          dp_out, dp_out_h0, frame_start, frame_start_h0;

  int checks = 0;
  int errors = 0;
  int p = 0;
  int txn = 0;

  logic [4*N-1:0] sh_code;
  logic [N-1:0]   sh_dp, sh_blank, sh_blink;
  logic [BW-1:0]  sh_bright;

  always #5 clock = ~clock;

  seg7_scan_driver #(.NUM_DIGITS(N), .TICK_DIV(TD), .BRIGHT_W(BW),
                     .BLINK_FRAMES(BF), .HEX_EN(1)) dut (
    .clock(clock), .reset(reset), .digits_code(digits_code), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .brightness(brightness),
    .anode(anode), .segments(segments), .dp_out(dp_out), .frame_start(frame_start));

  seg7_scan_driver #(.NUM_DIGITS(N), .TICK_DIV(TD), .BRIGHT_W(BW),
                     .BLINK_FRAMES(BF), .HEX_EN(0)) dut_nohex (
    .clock(clock), .reset(reset), .digits_code(digits_code), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .brightness(brightness),
    .anode(anode_h0), .segments(segments_h0), .dp_out(dp_out_h0),
    .frame_start(frame_start_h0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t pos=%0d got %0h expected %0h", tag, $time, p, obs, exp);
    end
  endtask

  // Expected outputs for counter position q (cycles since the first post-reset cycle).
  task automatic model(input int q, input bit hex, output logic [N-1:0] an,
                       output logic [6:0] sg, output logic d);
    int frame, dig, ph;
    bit bp, lit;
    logic [3:0] code;
    frame = q / FRAME;
    dig   = (q % FRAME) / SLOT;
    ph    = (q % SLOT) / TD;
    bp    = ((frame / BF) % 2) == 1;
    code  = sh_code[dig*4 +: 4];
    lit   = (ph < int'(sh_bright)) && !sh_blank[dig] && !(sh_blink[dig] && bp) &&
            (code < 4'd10 || hex);
    an = '1;
    sg = 7'h7F;
    d  = 1'b1;
    if (lit) begin
      an[dig] = 1'b0;
      sg = SEG_TAB[code];
      d  = ~sh_dp[dig];
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] ea, eah;
    logic [6:0]   es, esh;
    logic         ed, edh;
    if (p == 0) begin
      ea = '1; es = 7'h7F; ed = 1'b1;
      eah = '1; esh = 7'h7F; edh = 1'b1;
    end else begin
      model(p - 1, 1'b1, ea, es, ed);
      model(p - 1, 1'b0, eah, esh, edh);
    end
    chk("frame_start", 32'(frame_start), 32'(p % FRAME == 0));
    chk("anode", 32'(anode), 32'(ea));
    chk("segments", 32'(segments), 32'(es));
    chk("dp_out", 32'(dp_out), 32'(ed));
    chk("nohex_frame_start", 32'(frame_start_h0), 32'(p % FRAME == 0));
    chk("nohex_anode", 32'(anode_h0), 32'(eah));
    chk("nohex_segments", 32'(segments_h0), 32'(esh));
    chk("nohex_dp_out", 32'(dp_out_h0), 32'(edh));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      if (p % FRAME == 0) begin
        sh_code = digits_code; sh_dp = dp_in; sh_blank = blank_in;
        sh_blink = blink_in; sh_bright = brightness;
      end
      @(negedge clock);
      p++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_segments", 32'(segments), 32'h7F);
    chk("rst_dp_out", 32'(dp_out), 32'h1);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    reset = 1'b0;
    p = 0;
    #1;
  endtask

  task automatic note(input string what);
    txn++;
    $display("txn %0d %s: code=%h dp=%b blank=%b blink=%b bright=%0d pos=%0d",
             txn, what, digits_code, dp_in, blank_in, blink_in, brightness, p);
  endtask

  task automatic randomize_inputs();
    digits_code = 16'($urandom);
    dp_in       = 4'($urandom);
    blank_in    = 4'($urandom) & 4'($urandom);
    blink_in    = 4'($urandom);
    brightness  = 2'($urandom);
  endtask

  initial begin
    digits_code = 16'h1234;
    brightness  = 2'd3;
    do_reset();
    note("reset_scan_1234");
    run(70);
    digits_code = 16'h9999;
    note("mid_frame_9999");
    run(60);
    brightness = 2'd0;
    note("brightness_0");
    run(40);
    brightness = 2'd1;
    note("brightness_1");
    run(40);
    digits_code = 16'h123A;
    dp_in = 4'b0001;
    brightness = 2'd3;
    note("hex_a_dp0");
    run(70);
    blink_in = 4'b0010;
    blank_in = 4'b0100;
    dp_in = 4'b0000;
    note("blink1_blank2");
    run(6 * FRAME);
    for (int k = 0; k < 25; k++) begin
      randomize_inputs();
      note("random");
      run($urandom_range(3, 45));
    end
    run(5);
    note("reset_mid_slot");
    do_reset();
    run(7 * FRAME);
    for (int k = 0; k < 10; k++) begin
      randomize_inputs();
      note("random_after_reset");
      run($urandom_range(10, 60));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
